// File: rtl/cpc_wait_ctrl.sv
// Z80 wait-state controller for the CPC bus: aligns CPU accesses to a gate-array slot phase.
// Optional wait-tick statistics counter is compiled in when WAIT_STATS_EN is defined.
//
// state | meaning
// IDLE  | no wait pending; wait_n released
// ALIGN | access started off-phase; holding wait_n low until RELEASE_PH
// EXTRA | aligned IO/INTack access; holding wait_n low for IO_EXTRA ticks
module cpc_wait_ctrl #(
   parameter int SLOT_LEN   = 4,
   parameter int RELEASE_PH = 0,
   parameter int IO_EXTRA   = 1,
   parameter int MAX_WAIT   = 15
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        ce_4p,
   input  logic                        slot_sync,
   input  logic                        no_wait,
   input  logic                        mreq_n,
   input  logic                        iorq_n,
   input  logic                        rfsh_n,
   input  logic                        m1_n,
   output logic                        wait_n,
   output logic [$clog2(SLOT_LEN)-1:0] phase,
   output logic                        busy,
   output logic                        timeout,
   output logic [15:0]                 wait_count
);

   localparam int PH_W = $clog2(SLOT_LEN);

   localparam logic [PH_W-1:0] PH_LAST = PH_W'(SLOT_LEN - 1);
   localparam logic [PH_W-1:0] PH_REL  = PH_W'(RELEASE_PH);
   localparam logic [2:0]      X_LOAD  = 3'(IO_EXTRA);
   localparam logic [7:0]      WD_LAST = 8'(MAX_WAIT - 1);
   localparam logic            HAS_XTR = (IO_EXTRA > 0);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ALIGN = 2'd1,
      EXTRA = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [PH_W-1:0] phase_q, phase_d;
   logic            old_acc_q, old_acc_d;
   logic            wait_n_q, wait_n_d;
   logic            busy_q, busy_d;
   logic            timeout_q, timeout_d;
   logic [2:0]      xcnt_q, xcnt_d;
   logic [7:0]      wcnt_q, wcnt_d;

   logic [PH_W-1:0] cur_ph;
   logic [PH_W-1:0] nxt_ph;
   logic            acc;
   logic            acc_start;
   logic            is_intack;
   logic            is_io;
   logic            at_rel;
   logic            go_extra;

   // Slot phase and bus strobe decode
   always_comb begin
      cur_ph    = slot_sync ? '0 : phase_q;
      nxt_ph    = (cur_ph == PH_LAST) ? '0 : cur_ph + 1'b1;
      at_rel    = (cur_ph == PH_REL);
      acc       = (mreq_n | ~rfsh_n) & iorq_n;
      acc_start = old_acc_q & ~acc;
      is_intack = ~m1_n & ~iorq_n;
      is_io     = ~iorq_n | is_intack;
      go_extra  = is_io & HAS_XTR;
   end

   always_comb begin
      state_d   = state_q;
      phase_d   = phase_q;
      old_acc_d = old_acc_q;
      wait_n_d  = wait_n_q;
      timeout_d = timeout_q;
      xcnt_d    = xcnt_q;
      wcnt_d    = wcnt_q;

      if (ce_4p) begin
         phase_d   = nxt_ph;
         old_acc_d = acc;

         if (no_wait) begin
            state_d  = IDLE;
            wait_n_d = 1'b1;
         end else begin
            case (state_q)
               IDLE: begin
                  if (acc_start) begin
                     if (at_rel) begin
                        if (go_extra) begin
                           state_d  = EXTRA;
                           xcnt_d   = X_LOAD;
                           wcnt_d   = '0;
                           wait_n_d = 1'b0;
                        end else begin
                           wait_n_d = 1'b1;
                        end
                     end else begin
                        state_d  = ALIGN;
                        wcnt_d   = '0;
                        wait_n_d = 1'b0;
                     end
                  end
               end

               ALIGN, EXTRA: begin
                  if (acc) begin
                     state_d  = IDLE;
                     wait_n_d = 1'b1;
                  end else if (wcnt_q == WD_LAST) begin
                     state_d   = IDLE;
                     wait_n_d  = 1'b1;
                     timeout_d = 1'b1;
                  end else begin
                     // Watchdog keeps running across ALIGN->EXTRA so the total low time stays bounded
                     wcnt_d = wcnt_q + 8'd1;
                     if (state_q == ALIGN) begin
                        if (at_rel) begin
                           if (go_extra) begin
                              state_d = EXTRA;
                              xcnt_d  = X_LOAD;
                           end else begin
                              state_d  = IDLE;
                              wait_n_d = 1'b1;
                           end
                        end
                     end else begin
                        if (xcnt_q == 3'd1) begin
                           state_d  = IDLE;
                           wait_n_d = 1'b1;
                        end else begin
                           xcnt_d = xcnt_q - 3'd1;
                        end
                     end
                  end
               end

               default: begin
                  state_d  = IDLE;
                  wait_n_d = 1'b1;
               end
            endcase
         end
      end

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         phase_q   <= '0;
         old_acc_q <= 1'b1;
         wait_n_q  <= 1'b1;
         busy_q    <= 1'b0;
         timeout_q <= 1'b0;
         xcnt_q    <= '0;
         wcnt_q    <= '0;
      end else begin
         state_q   <= state_d;
         phase_q   <= phase_d;
         old_acc_q <= old_acc_d;
         wait_n_q  <= wait_n_d;
         busy_q    <= busy_d;
         timeout_q <= timeout_d;
         xcnt_q    <= xcnt_d;
         wcnt_q    <= wcnt_d;
      end
   end

`ifdef WAIT_STATS_EN
   logic [15:0] wcount_q, wcount_d;

   always_comb begin
      wcount_d = wcount_q;
      if (ce_4p && !wait_n_q && (wcount_q != 16'hFFFF)) begin
         wcount_d = wcount_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wcount_q <= '0;
      end else begin
         wcount_q <= wcount_d;
      end
   end

   assign wait_count = wcount_q;
`else
   assign wait_count = 16'h0000;
`endif

   assign wait_n  = wait_n_q;
   assign phase   = phase_q;
   assign busy    = busy_q;
   assign timeout = timeout_q;

endmodule

// File: tb/tb_cpc_wait_ctrl.sv
// Directed bench for cpc_wait_ctrl: default instance plus a SLOT_LEN=8 / MAX_WAIT=3 instance.
module tb_cpc_wait_ctrl;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic ce_4p = 1'b1;
   logic slot_sync = 1'b0;
   logic slot_sync1 = 1'b0;
   logic no_wait = 1'b0;
   logic mreq_n = 1'b1;
   logic iorq_n = 1'b1;
   logic rfsh_n = 1'b1;
   logic m1_n = 1'b1;

   logic        wait_n0, busy0, timeout0;
   logic [1:0]  phase0;
   logic [15:0] wcount0;
   logic        wait_n1, busy1, timeout1;
   logic [2:0]  phase1;
   logic [15:0] wcount1;

   int total = 0;
   int bad = 0;
   int n;

`ifdef WAIT_STATS_EN
   localparam int EXP_STATS = 3;
`else
   localparam int EXP_STATS = 0;
`endif

   cpc_wait_ctrl u_dut0 (
      .clk(clk), .reset(reset), .ce_4p(ce_4p), .slot_sync(slot_sync),
      .no_wait(no_wait), .mreq_n(mreq_n), .iorq_n(iorq_n), .rfsh_n(rfsh_n),
      .m1_n(m1_n), .wait_n(wait_n0), .phase(phase0), .busy(busy0),
      .timeout(timeout0), .wait_count(wcount0)
   );

   cpc_wait_ctrl #(.SLOT_LEN(8), .MAX_WAIT(3)) u_dut1 (
      .clk(clk), .reset(reset), .ce_4p(ce_4p), .slot_sync(slot_sync1),
      .no_wait(no_wait), .mreq_n(mreq_n), .iorq_n(iorq_n), .rfsh_n(rfsh_n),
      .m1_n(m1_n), .wait_n(wait_n1), .phase(phase1), .busy(busy1),
      .timeout(timeout1), .wait_count(wcount1)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   function automatic int ph(input int sel);
      return (sel == 1) ? int'(phase1) : int'(phase0);
   endfunction

   function automatic logic wn(input int sel);
      return (sel == 1) ? wait_n1 : wait_n0;
   endfunction

   task automatic wait_phase(input int sel, input int p);
      int k = 0;
      while (ph(sel) != p && k < 20) begin
         tick();
         k++;
      end
      chk("ph_reach", ph(sel), p);
   endtask

   // First tick is the access-start tick; counts ticks with wait_n low afterwards.
   task automatic measure(input int sel, output int cnt);
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (wn(sel)) break;
         cnt++;
      end
   endtask

   task automatic bus_idle();
      mreq_n = 1'b1;
      iorq_n = 1'b1;
      rfsh_n = 1'b1;
      m1_n   = 1'b1;
      tick();
   endtask

   initial begin
      do_reset();
      chk("rst_wait_n", wait_n0, 1);
      chk("rst_phase", phase0, 0);
      chk("rst_busy", busy0, 0);
      chk("rst_timeout", timeout0, 0);
      chk("rst_wcount", wcount0, 0);

      repeat (3) tick();
      chk("phase_run", phase0, 3);
      tick();
      chk("phase_wrap", phase0, 0);

      // memory access at phase 2
      wait_phase(0, 2);
      mreq_n = 1'b0;
      tick();
      chk("mem2_wn_start", wait_n0, 0);
      chk("mem2_busy", busy0, 1);
      tick();
      chk("mem2_wn_mid", wait_n0, 0);
      tick();
      chk("mem2_wn_rel", wait_n0, 1);
      chk("mem2_busy_rel", busy0, 0);
      chk("mem2_ph_rel", phase0, 1);
      chk("mem2_timeout", timeout0, 0);
      bus_idle();

      wait_phase(0, 0);
      iorq_n = 1'b0;
      measure(0, n);
      chk("io0_len", n, 1);
      bus_idle();

      wait_phase(0, 2);
      iorq_n = 1'b0;
      measure(0, n);
      chk("io2_len", n, 3);
      bus_idle();

      wait_phase(0, 1);
      iorq_n = 1'b0;
      m1_n = 1'b0;
      measure(0, n);
      chk("intack1_len", n, 4);
      bus_idle();

      wait_phase(0, 1);
      mreq_n = 1'b0;
      rfsh_n = 1'b0;
      measure(0, n);
      chk("rfsh_len", n, 0);
      chk("rfsh_busy", busy0, 0);
      bus_idle();

      wait_phase(0, 0);
      mreq_n = 1'b0;
      measure(0, n);
      chk("mem0_len", n, 0);
      bus_idle();

      wait_phase(0, 3);
      mreq_n = 1'b0;
      measure(0, n);
      chk("mem3_len", n, 1);
      bus_idle();

      // abort: strobe withdrawn during ALIGN
      wait_phase(0, 1);
      mreq_n = 1'b0;
      tick();
      tick();
      chk("abort_wn_pre", wait_n0, 0);
      chk("abort_busy_pre", busy0, 1);
      mreq_n = 1'b1;
      tick();
      chk("abort_wn", wait_n0, 1);
      chk("abort_busy", busy0, 0);
      bus_idle();

      wait_phase(0, 1);
      mreq_n = 1'b0;
      tick();
      chk("nw_wn_pre", wait_n0, 0);
      no_wait = 1'b1;
      tick();
      chk("nw_wn", wait_n0, 1);
      chk("nw_busy", busy0, 0);
      bus_idle();
      wait_phase(0, 2);
      mreq_n = 1'b0;
      measure(0, n);
      chk("nw_access_len", n, 0);
      no_wait = 1'b0;
      bus_idle();

      // ce_4p low freezes everything
      wait_phase(0, 1);
      mreq_n = 1'b0;
      tick();
      ce_4p = 1'b0;
      repeat (3) tick();
      chk("ce_hold_wn", wait_n0, 0);
      chk("ce_hold_ph", phase0, 2);
      chk("ce_hold_busy", busy0, 1);
      ce_4p = 1'b1;
      measure(0, n);
      chk("ce_rest_len", n, 2);
      bus_idle();

      wait_phase(0, 2);
      slot_sync = 1'b1;
      tick();
      slot_sync = 1'b0;
      chk("sync_ph", phase0, 1);

      wait_phase(0, 2);
      slot_sync = 1'b1;
      mreq_n = 1'b0;
      measure(0, n);
      slot_sync = 1'b0;
      chk("sync_acc_len", n, 0);
      chk("sync_acc_ph", phase0, 1);
      bus_idle();
      chk("dflt_timeout", timeout0, 0);

      // watchdog on the SLOT_LEN=8 / MAX_WAIT=3 instance
      do_reset();
      chk("wd_rst_timeout", timeout1, 0);
      wait_phase(1, 1);
      mreq_n = 1'b0;
      measure(1, n);
      chk("wd_len", n, 3);
      chk("wd_timeout", timeout1, 1);
      chk("wd_busy", busy1, 0);
      chk("wd_dflt_timeout", timeout0, 0);
      bus_idle();
      repeat (5) tick();
      chk("wd_sticky", timeout1, 1);
      do_reset();
      chk("wd_clr", timeout1, 0);

      // statistics: three single-tick waits
      repeat (3) begin
         wait_phase(0, 3);
         mreq_n = 1'b0;
         measure(0, n);
         chk("stat_len", n, 1);
         bus_idle();
      end
      chk("stat_count", wcount0, EXP_STATS);

      // async reset mid-wait releases wait_n immediately
      wait_phase(0, 1);
      mreq_n = 1'b0;
      tick();
      chk("ar_wn_pre", wait_n0, 0);
      #2;
      reset = 1'b1;
      #1;
      chk("ar_wn", wait_n0, 1);
      chk("ar_busy", busy0, 0);
      mreq_n = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cpc_wait_ctrl.md
# cpc_wait_ctrl

Parametrised Z80 bus wait-state controller for the CPC motherboard. It replaces the ad-hoc WAIT_n register next to the T80pa instance. It tracks the gate-array slot phase, detects the start of each CPU memory or IO access, and holds the CPU's wait_n low until the access is aligned to a configurable release phase. IO accesses can be given extra wait ticks. Adds a watchdog timeout and optional wait-tick statistics.

## Interface
Parameters:
- SLOT_LEN, 4: ce_4p ticks per bus slot (4 = 1 MHz slot); legal range 2..16.
- RELEASE_PH, 0: slot phase on which an aligned access is released; must be < SLOT_LEN.
- IO_EXTRA, 1: extra wait ticks added after alignment for IO and INTack cycles; 0..7.
- MAX_WAIT, 15: watchdog limit in ticks of continuous wait; 1..255.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  asynchronous, active-high reset.
- ce_4p  in  1  4 MHz clock enable; all state advances only on clk edges with ce_4p=1 ("ticks").
- slot_sync  in  1  marks the current tick as slot phase 0 (driven from gate-array cyc1MHz).
- no_wait  in  1  1 = wait generation disabled.
- mreq_n, iorq_n, rfsh_n, m1_n  in  1 each  Z80 bus strobes from T80pa.
- wait_n  out  1  registered wait request to the CPU.
- phase  out  $clog2(SLOT_LEN)  registered slot phase.
- busy  out  1  state != IDLE.
- timeout  out  1  sticky watchdog flag.
- wait_count  out  16  wait-tick statistics (see Configuration).

## Operation
- Current phase: cur_ph = slot_sync ? 0 : phase. Next phase = (cur_ph == SLOT_LEN-1) ? 0 : cur_ph+1.
- Access signal: acc = (mreq_n | ~rfsh_n) & iorq_n. Refresh cycles never count as accesses.
- The acc value is registered each tick as old_acc. Access start = old_acc & ~acc.
- is_io = ~iorq_n. This includes INTack (m1_n=0 & iorq_n=0).
- IDLE:
  - On access start with cur_ph == RELEASE_PH: if is_io and IO_EXTRA>0, go to EXTRA (xcnt=IO_EXTRA, wait_n=0). Otherwise stay in IDLE with wait_n=1 (zero-wait aligned access).
  - On access start with any other phase: go to ALIGN with wait_n=0.
- ALIGN: on cur_ph == RELEASE_PH, go to EXTRA if is_io and IO_EXTRA>0 (xcnt=IO_EXTRA). Otherwise go to IDLE with wait_n=1.
- EXTRA: decrement xcnt each tick. When xcnt==1, go to IDLE with wait_n=1.
- Watchdog: wcnt resets to 0 on entry to ALIGN or EXTRA and increments each tick in those states. When wcnt reaches MAX_WAIT-1, force IDLE with wait_n=1 and set timeout=1. timeout is cleared only by reset.
- Abort: if acc returns to 1 while in ALIGN or EXTRA, go to IDLE with wait_n=1 on that tick.
- no_wait=1 forces IDLE and wait_n=1 on every tick. Phase tracking and old_acc continue to update.
- Simultaneous events: the priority order is no_wait > abort > watchdog > normal transitions. slot_sync is honoured even when it coincides with an access start.

## Timing
- Reset values: phase=0, state=IDLE, wait_n=1, busy=0, timeout=0, wait_count=0, old_acc=1.
- Reset is asynchronous. Asserting it mid-wait releases wait_n immediately (combinationally through the flop reset).
- wait_n is updated on the tick that detects the access start and is visible to the CPU from the next clk edge.
- Wait length for a memory access starting at phase p: (RELEASE_PH - p) mod SLOT_LEN ticks. Add IO_EXTRA ticks for IO accesses.
- The maximum wait_n=0 duration is MAX_WAIT ticks.
- Outputs do not change on clk edges without ce_4p.

## Configuration
- WAIT_STATS_EN defined:
  - wait_count increments on every tick where the registered wait_n=0.
  - It saturates at 16'hFFFF and clears only on reset.
- WAIT_STATS_EN undefined:
  - The counter logic is not compiled.
  - wait_count is tied to 16'h0000.
  - The port list is unchanged.

## Test plan
All scenarios use default parameters unless stated.
- Memory access start at phase 2: wait_n=0 for exactly 2 ticks, released on the phase-0 tick, busy 1→0, timeout=0.
- IO access start at phase 0: wait_n=0 for exactly 1 tick (IO_EXTRA=1), then returns to 1.
- Refresh cycle (mreq_n=0, rfsh_n=0) at phase 1: wait_n stays 1 and state stays IDLE.
- With SLOT_LEN=8 and MAX_WAIT=3, memory access starting at phase 1: wait_n=0 for 3 ticks, forced release, timeout=1. timeout stays 1 until reset.
- no_wait asserted during ALIGN: wait_n=1 on the next tick. A subsequent access start with no_wait=1 produces no wait.
- With WAIT_STATS_EN, issue three memory accesses starting at phase 3 (1 wait tick each): wait_count=3. Without the macro, wait_count stays 0.
